// File: rtl/act_pkg.sv
// Shared definitions for the activation unit.
//   act_mode_e : per-beat activation mode carried on in_mode
//   SAT_CNT_W  : width of the optional saturation event counter
package act_pkg;

    typedef enum logic [1:0] {
        ACT_RELU  = 2'd0,
        ACT_LEAKY = 2'd1,
        ACT_IDENT = 2'd2,
        ACT_RSVD  = 2'd3
    } act_mode_e;

    localparam int unsigned SAT_CNT_W = 16;

endpackage

// File: rtl/activation_unit_if.sv
// Stream bundle between a producer/consumer (master) and the activation unit (slave).
//   in_valid/in_ready/in_data/in_mode : input beat handshake, NUM_CH signed 2*DATA_WIDTH lanes
//   out_valid/out_ready/out_data      : output beat handshake, NUM_CH DATA_WIDTH lanes
//   sat_flag                          : per-lane saturation of the beat on out_data
//   sat_count/sat_clr                 : statistics, present only with ACT_UNIT_STATS_EN
interface activation_unit_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_CH     = 4
) ();
    import act_pkg::*;

    logic                           in_valid;
    logic                           in_ready;
    logic [NUM_CH*2*DATA_WIDTH-1:0] in_data;
    logic [1:0]                     in_mode;
    logic                           out_valid;
    logic                           out_ready;
    logic [NUM_CH*DATA_WIDTH-1:0]   out_data;
    logic [NUM_CH-1:0]              sat_flag;
`ifdef ACT_UNIT_STATS_EN
    logic [SAT_CNT_W-1:0]           sat_count;
    logic                           sat_clr;

    modport master (
        output in_valid, in_data, in_mode, out_ready, sat_clr,
        input  in_ready, out_valid, out_data, sat_flag, sat_count
    );
    modport slave (
        input  in_valid, in_data, in_mode, out_ready, sat_clr,
        output in_ready, out_valid, out_data, sat_flag, sat_count
    );
`else
    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, sat_flag
    );
    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, sat_flag
    );
`endif

endinterface

// File: rtl/act_sat_lane.sv
// Per-lane slice and saturation (combinational).
//   i_v    : upper DATA_WIDTH+INT_WIDTH bits of the stage-1 lane value v
//   o_data : v sliced to the output format, clamped on overflow
//   o_sat  : high when o_data was clamped
module act_sat_lane #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned INT_WIDTH  = 4
) (
    input  logic [DATA_WIDTH+INT_WIDTH-1:0] i_v,
    output logic [DATA_WIDTH-1:0]           o_data,
    output logic                            o_sat
);
    localparam int unsigned VW = DATA_WIDTH + INT_WIDTH;

    // Sign bit plus the integer bits dropped by the slice; they must all equal the sign.
    logic [INT_WIDTH:0] w_top;
    assign w_top = i_v[VW-1 -: INT_WIDTH+1];

    always_comb begin
        o_data = i_v[DATA_WIDTH-1:0];
        o_sat  = 1'b0;
        if (!i_v[VW-1] && (|w_top)) begin
            o_data = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            o_sat  = 1'b1;
        end else if (i_v[VW-1] && !(&w_top)) begin
            o_data = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            o_sat  = 1'b1;
        end
    end

endmodule

// File: rtl/activation_unit.sv
// Two-stage activation pipeline: stage 1 applies ReLU / leaky ReLU / identity per lane,
// stage 2 slices to DATA_WIDTH and saturates. A single advance enable stalls the whole pipe.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : activation_unit_if slave (input/output handshakes, sat_flag)
// Optional: define ACT_UNIT_STATS_EN to add sat_count (saturated-lane counter) and sat_clr.
module activation_unit
    import act_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned INT_WIDTH  = 4,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned LEAK_SHIFT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    activation_unit_if.slave   bus
);
    localparam int unsigned LW = 2 * DATA_WIDTH;
    // Only the top bits of v survive the slice, so stage 1 keeps just those.
    localparam int unsigned VW = DATA_WIDTH + INT_WIDTH;

    logic                            w_en;
    logic [NUM_CH-1:0][VW-1:0]       w_s1_v;
    logic [NUM_CH*DATA_WIDTH-1:0]    w_lane_data;
    logic [NUM_CH-1:0]               w_lane_sat;

    logic                            r_s1_valid;
    logic [NUM_CH-1:0][VW-1:0]       r_s1_v;
    logic                            r_out_valid;
    logic [NUM_CH*DATA_WIDTH-1:0]    r_out_data;
    logic [NUM_CH-1:0]               r_sat_flag;

    assign w_en         = !r_out_valid || bus.out_ready;
    assign bus.in_ready = w_en;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        logic signed [VW-1:0] w_x;
        logic signed [VW-1:0] w_v;

        // Arithmetic shift of the top slice equals the top slice of the full-width shift.
        assign w_x = bus.in_data[k*LW + LW - VW +: VW];

        always_comb begin
            w_v = w_x;
            if (w_x[VW-1]) begin
                case (act_mode_e'(bus.in_mode))
                    ACT_LEAKY: w_v = w_x >>> LEAK_SHIFT;
                    ACT_IDENT: w_v = w_x;
                    default:   w_v = '0; // ReLU; reserved mode decodes as ReLU
                endcase
            end
        end

        assign w_s1_v[k] = w_v;

        act_sat_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .INT_WIDTH  (INT_WIDTH)
        ) u_sat_lane (
            .i_v    (r_s1_v[k]),
            .o_data (w_lane_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .o_sat  (w_lane_sat[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_v      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_sat_flag  <= '0;
        end else if (w_en) begin
            r_s1_valid  <= bus.in_valid;
            r_out_valid <= r_s1_valid;
            if (bus.in_valid) begin
                r_s1_v <= w_s1_v;
            end
            if (r_s1_valid) begin
                r_out_data <= w_lane_data;
                r_sat_flag <= w_lane_sat;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.sat_flag  = r_sat_flag;

`ifdef ACT_UNIT_STATS_EN
    logic [SAT_CNT_W-1:0] r_sat_count;
    logic [SAT_CNT_W:0]   w_sat_sum;

    // One extra bit catches the wrap so the counter can stick at all ones.
    assign w_sat_sum = {1'b0, r_sat_count} + (SAT_CNT_W+1)'($countones(r_sat_flag));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_count <= '0;
        end else if (bus.sat_clr) begin
            r_sat_count <= '0;
        end else if (r_out_valid && bus.out_ready) begin
            r_sat_count <= w_sat_sum[SAT_CNT_W] ? '1 : w_sat_sum[SAT_CNT_W-1:0];
        end
    end

    assign bus.sat_count = r_sat_count;
`endif

endmodule

// File: doc/activation_unit.md
ACTIVATION_UNIT -- requirements
Module: activation_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: output lane width in bits.
REQ-002 SHALL have parameter INT_WIDTH, default 4: integer bits of the weight format.
REQ-003 SHALL have parameter NUM_CH, default 4: number of parallel lanes.
REQ-004 SHALL have parameter LEAK_SHIFT, default 3: arithmetic right shift that forms the leaky slope, 2^-LEAK_SHIFT.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port in_valid, input, 1 bit: the input beat is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts a beat.
REQ-009 SHALL have port in_data, input, NUM_CH*2*DATA_WIDTH bits: signed products, lane k at bits [k*2*DATA_WIDTH +: 2*DATA_WIDTH].
REQ-010 SHALL have port in_mode, input, 2 bits: per-beat mode; 0 ReLU, 1 leaky ReLU, 2 saturating identity, 3 reserved (behaves as 0).
REQ-011 SHALL have port out_valid, output, 1 bit: the output beat is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream sink accepts a beat.
REQ-013 SHALL have port out_data, output, NUM_CH*DATA_WIDTH bits: activated lanes, packed the same way as in_data.
REQ-014 SHALL have port sat_flag, output, NUM_CH bits: per-lane saturation for the beat on out_data.

Function
REQ-015 SHALL be a 2-stage pipeline: stage 1 applies the mode operation, stage 2 applies slice and saturation, both registered.
REQ-016 SHALL use a global advance enable en = !out_valid || out_ready; in_ready = en; the whole pipeline stalls when en is 0.
REQ-017 SHALL transfer a beat on in_valid && in_ready, and present its result on out_valid exactly 2 cycles later when never stalled.
REQ-018 SHALL hold out_data, out_valid and sat_flag stable while out_valid && !out_ready.
REQ-019 SHALL form stage-1 lane value v as: v = x if x >= 0; otherwise v = 0 in mode 0, v = x >>> LEAK_SHIFT in mode 1, v = x in mode 2.
REQ-020 SHALL take the nominal output as v[2*DATA_WIDTH-1-INT_WIDTH -: DATA_WIDTH] (truncation, no rounding).
REQ-021 SHALL saturate positive v to {0, all ones} (e.g. 0x7FFF) when any bit of v[2*DATA_WIDTH-1 -: INT_WIDTH+1] is 1.
REQ-022 SHALL saturate negative v to {1, all zeros} (e.g. 0x8000) when v[2*DATA_WIDTH-1 -: INT_WIDTH+1] is not all ones.
REQ-023 SHALL set sat_flag[k] only when lane k was saturated under REQ-021 or REQ-022.
REQ-024 SHALL carry the mode with its beat through stage 1, so that a mode change between consecutive beats never affects a beat already accepted.
REQ-025 SHALL continue to accept on the same edge on which the output is consumed, with no bubble, when the pipeline is full and out_ready is 1.

Reset
REQ-026 SHALL, on rst_n low, immediately clear both stage-valid bits and set out_data = 0, sat_flag = 0, out_valid = 0, independent of clk.
REQ-027 SHALL drop any beat in flight at reset, and present in_ready = 1 in the first cycle after rst_n deasserts.

Configuration
REQ-028 SHALL, when macro ACT_UNIT_STATS_EN is defined, add output sat_count[15:0] and input sat_clr.
REQ-029 SHALL, with ACT_UNIT_STATS_EN defined, add to sat_count the number of set sat_flag bits on each out_valid && out_ready, saturating at 0xFFFF.
REQ-030 SHALL, with ACT_UNIT_STATS_EN defined, make sat_clr synchronous, taking priority over an increment on the same edge; sat_count resets to 0.
REQ-031 SHALL, without ACT_UNIT_STATS_EN, have neither port nor counter, and all other behaviour SHALL be identical.

Structure
REQ-032 SHALL keep the mode encodings (ACT_RELU = 0, ACT_LEAKY = 1, ACT_IDENT = 2) and the sat-count width in shared package act_pkg.
REQ-033 SHALL place the per-lane slice and saturation logic in sub-module act_sat_lane, instantiated NUM_CH times by generate.

Verification (DATA_WIDTH=16, INT_WIDTH=4, LEAK_SHIFT=3)
REQ-034 SHALL cover: mode 0, lane x = 0x0000_1000 -> 0x0001, sat 0; x = 0x0800_0000 -> 0x7FFF, sat 1; x = 0xFFFF_F000 -> 0x0000.
REQ-035 SHALL cover: mode 1, x = 0xFFFF_F000 -> 0xFFFF; x = 0x8000_0000 -> 0x8000, sat 1; mode 2, x = 0xFFF0_0000 -> 0xFF00, sat 0.
REQ-036 SHALL cover: 10 back-to-back beats with out_ready = 1 -> 10 outputs in order, first out_valid 2 cycles after the first accept, no bubbles.
REQ-037 SHALL cover: out_ready held 0 for 5 cycles with the pipe full -> in_ready = 0 and out_data stable; on release, no beat is lost or duplicated.
REQ-038 SHALL cover: rst_n pulsed low mid-stream with 2 beats in flight -> out_valid = 0 at once and no stale beat after release.
REQ-039 SHALL cover, with ACT_UNIT_STATS_EN defined: 3 beats each saturating 2 lanes -> sat_count = 6; sat_clr together with a saturating beat -> sat_count = 0.
